// File: rtl/accelerator_vector_hyperbolic_function.sv
// Vector cosh/sinh accelerator: buffers input elements in a small FIFO and
// streams them one at a time through a truncated-Maclaurin scalar unit.

module accelerator_scalar_series #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter bit ODD          = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic                 READY,
  output logic [DATA_SIZE-1:0] DATA_OUT
);
  localparam int MAX_TERMS = 32;

  logic                    busy_q;
  logic                    ready_q;
  logic [DATA_SIZE-1:0]    x2_q;
  logic [DATA_SIZE-1:0]    term_q;
  logic [DATA_SIZE-1:0]    acc_q;
  logic [DATA_SIZE-1:0]    out_q;
  logic [CONTROL_SIZE-1:0] n_q;
  logic [CONTROL_SIZE-1:0] it_q;
  logic [DATA_SIZE-1:0]    den;
  logic [DATA_SIZE-1:0]    term_d;
  logic                    done;

  // Next term t*x^2/((n+1)(n+2)); stop once a term truncates to zero.
  always_comb begin
    den    = DATA_SIZE'(n_q + CONTROL_SIZE'(1))
           * DATA_SIZE'(n_q + CONTROL_SIZE'(2));
    term_d = (term_q * x2_q) / den;
    done   = (term_q == '0) || (it_q == CONTROL_SIZE'(MAX_TERMS));
  end

  // Series accumulator: seed on START, add one term per cycle, pulse READY.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      x2_q    <= '0;
      term_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      n_q     <= '0;
      it_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      if (START) begin
        busy_q <= 1'b1;
        x2_q   <= DATA_IN * DATA_IN;
        term_q <= ODD ? DATA_IN : DATA_SIZE'(1);
        acc_q  <= ODD ? DATA_IN : DATA_SIZE'(1);
        n_q    <= ODD ? CONTROL_SIZE'(1) : '0;
        it_q   <= '0;
      end else if (busy_q) begin
        if (done) begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          out_q   <= acc_q;
        end else begin
          term_q <= term_d;
          acc_q  <= acc_q + term_d;
          n_q    <= n_q + CONTROL_SIZE'(2);
          it_q   <= it_q + CONTROL_SIZE'(1);
        end
      end
    end
  end

  assign READY    = ready_q;
  assign DATA_OUT = out_q;
endmodule

module accelerator_scalar_cosh_function #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic                 READY,
  output logic [DATA_SIZE-1:0] DATA_OUT
);
  accelerator_scalar_series #(
    .DATA_SIZE(DATA_SIZE), .CONTROL_SIZE(CONTROL_SIZE), .ODD(1'b0)
  ) u_series (
    .CLK(CLK), .RST(RST), .START(START), .DATA_IN(DATA_IN),
    .READY(READY), .DATA_OUT(DATA_OUT)
  );
endmodule

module accelerator_scalar_sinh_function #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic                 READY,
  output logic [DATA_SIZE-1:0] DATA_OUT
);
  accelerator_scalar_series #(
    .DATA_SIZE(DATA_SIZE), .CONTROL_SIZE(CONTROL_SIZE), .ODD(1'b1)
  ) u_series (
    .CLK(CLK), .RST(RST), .START(START), .DATA_IN(DATA_IN),
    .READY(READY), .DATA_OUT(DATA_OUT)
  );
endmodule

module accelerator_vector_hyperbolic_function #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 MODE,
  input  logic [DATA_SIZE-1:0] SIZE_IN,
  input  logic                 DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic                 READY,
  output logic                 DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 FIFO_FULL,
  output logic                 OVERFLOW
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    STARTER_STATE,
    ISSUE_STATE,
    WAIT_STATE
  } state_t;

  state_t                  state_q;
  logic                    mode_q;
  logic [CONTROL_SIZE-1:0] size_q;
  logic [CONTROL_SIZE-1:0] in_cnt_q;
  logic [CONTROL_SIZE-1:0] out_cnt_q;
  logic [CONTROL_SIZE-1:0] size_d;
  logic [DATA_SIZE-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_q;
  logic [AW-1:0]           rd_q;
  logic [AW:0]             occ_q;
  logic [AW:0]             occ_d;
  logic                    ovf_q;
  logic                    ready_q;
  logic                    doe_q;
  logic [DATA_SIZE-1:0]    dout_q;
  logic                    cosh_start_q;
  logic                    sinh_start_q;
  logic [DATA_SIZE-1:0]    sdata_q;
  logic                    cosh_ready;
  logic                    sinh_ready;
  logic [DATA_SIZE-1:0]    cosh_out;
  logic [DATA_SIZE-1:0]    sinh_out;
  logic                    full;
  logic                    empty;
  logic                    accepting;
  logic                    push;
  logic                    pop;
  logic                    drop;
  logic                    unit_ready;
  logic [DATA_SIZE-1:0]    unit_out;

  // A popping head frees a slot, so a full FIFO still takes a push then.
  always_comb begin
    size_d     = CONTROL_SIZE'(SIZE_IN);
    full       = (occ_q == (AW+1)'(FIFO_DEPTH));
    empty      = (occ_q == '0);
    accepting  = (state_q != STARTER_STATE) && DATA_IN_ENABLE
               && (in_cnt_q < size_q);
    pop        = (state_q == ISSUE_STATE) && !empty;
    push       = accepting && (!full || pop);
    drop       = accepting && full && !pop;
    occ_d      = occ_q;
    if (push && !pop) occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
    unit_ready = mode_q ? sinh_ready : cosh_ready;
    unit_out   = mode_q ? sinh_out : cosh_out;
  end

  // Element storage; contents are don't-care while unoccupied.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_q] <= DATA_IN;
  end

  // Control FSM with FIFO pointers, counters and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= STARTER_STATE;
      mode_q       <= 1'b0;
      size_q       <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      occ_q        <= '0;
      ovf_q        <= 1'b0;
      ready_q      <= 1'b0;
      doe_q        <= 1'b0;
      dout_q       <= '0;
      cosh_start_q <= 1'b0;
      sinh_start_q <= 1'b0;
      sdata_q      <= '0;
    end else begin
      ready_q      <= 1'b0;
      doe_q        <= 1'b0;
      cosh_start_q <= 1'b0;
      sinh_start_q <= 1'b0;
      occ_q        <= occ_d;
      if (push) begin
        wr_q     <= wr_q + 1'b1;
        in_cnt_q <= in_cnt_q + CONTROL_SIZE'(1);
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (drop) ovf_q <= 1'b1;
      unique case (state_q)
        STARTER_STATE: begin
          if (START) begin
            mode_q    <= MODE;
            size_q    <= size_d;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            occ_q     <= '0;
            ovf_q     <= 1'b0;
            if (size_d == '0) ready_q <= 1'b1;
            else state_q <= ISSUE_STATE;
          end
        end
        ISSUE_STATE: begin
          if (!empty) begin
            sdata_q      <= mem_q[rd_q];
            cosh_start_q <= !mode_q;
            sinh_start_q <= mode_q;
            state_q      <= WAIT_STATE;
          end
        end
        WAIT_STATE: begin
          if (unit_ready) begin
            dout_q    <= unit_out;
            doe_q     <= 1'b1;
            out_cnt_q <= out_cnt_q + CONTROL_SIZE'(1);
            if (out_cnt_q == size_q - CONTROL_SIZE'(1)) begin
              ready_q <= 1'b1;
              state_q <= STARTER_STATE;
            end else begin
              state_q <= ISSUE_STATE;
            end
          end
        end
        default: state_q <= STARTER_STATE;
      endcase
    end
  end

  accelerator_scalar_cosh_function #(
    .DATA_SIZE(DATA_SIZE), .CONTROL_SIZE(CONTROL_SIZE)
  ) u_cosh (
    .CLK(CLK), .RST(RST), .START(cosh_start_q), .DATA_IN(sdata_q),
    .READY(cosh_ready), .DATA_OUT(cosh_out)
  );

  accelerator_scalar_sinh_function #(
    .DATA_SIZE(DATA_SIZE), .CONTROL_SIZE(CONTROL_SIZE)
  ) u_sinh (
    .CLK(CLK), .RST(RST), .START(sinh_start_q), .DATA_IN(sdata_q),
    .READY(sinh_ready), .DATA_OUT(sinh_out)
  );

  assign READY           = ready_q;
  assign DATA_OUT_ENABLE = doe_q;
  assign DATA_OUT        = dout_q;
  assign FIFO_FULL       = full;
  assign OVERFLOW        = ovf_q;
endmodule

// File: tb/tb_accelerator_vector_hyperbolic_function.sv
// Directed bench for the vector cosh/sinh accelerator.
// Expected results are hand-evaluated truncated series values.

module tb_accelerator_vector_hyperbolic_function;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [63:0] size_in = '0;
  logic        den = 1'b0;
  logic [63:0] din = '0;
  logic        ready;
  logic        doe;
  logic [63:0] dout;
  logic        ffull;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] outs[$];
  int rdy_n = 0;
  int rdy_doe_n = 0;
  int cs_n = 0;
  int ss_n = 0;

  always #5 clk = ~clk;

  accelerator_vector_hyperbolic_function #(
    .DATA_SIZE(64), .CONTROL_SIZE(64), .FIFO_DEPTH(4)
  ) dut (
    .CLK(clk), .RST(rst_n), .START(start), .MODE(mode),
    .SIZE_IN(size_in), .DATA_IN_ENABLE(den), .DATA_IN(din),
    .READY(ready), .DATA_OUT_ENABLE(doe), .DATA_OUT(dout),
    .FIFO_FULL(ffull), .OVERFLOW(ovf)
  );

  always @(negedge clk) begin
    if (doe) outs.push_back(dout);
    if (ready) begin
      rdy_n++;
      if (doe) rdy_doe_n++;
    end
    if (dut.cosh_start_q) cs_n++;
    if (dut.sinh_start_q) ss_n++;
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic go(logic m, logic [63:0] s);
    start = 1'b1;
    mode = m;
    size_in = s;
    tick();
    start = 1'b0;
  endtask

  task automatic send(logic [63:0] x);
    den = 1'b1;
    din = x;
    tick();
    den = 1'b0;
  endtask

  task automatic wait_out(int target);
    int k;
    k = 0;
    while (outs.size() < target && k < 400) begin
      tick();
      k++;
    end
    chk("wait_out", 64'(outs.size() >= target), 64'd1);
  endtask

  initial begin
    int b, r0, c0, s0, d0;
    logic full_seen;
    logic [63:0] v [8];

    // reset state
    ticks(3);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_doe", 64'(doe), 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_full", 64'(ffull), 64'd0);
    rst_n = 1'b1;
    ticks(2);

    // cosh, 3 elements: cosh(2)=3, cosh(3)=8, cosh(4)=25
    b = outs.size(); r0 = rdy_n; d0 = rdy_doe_n; c0 = cs_n; s0 = ss_n;
    go(1'b0, 64'd3);
    send(64'd2); wait_out(b + 1);
    send(64'd3); wait_out(b + 2);
    send(64'd4); wait_out(b + 3);
    ticks(5);
    chk("cosh_n", 64'(outs.size() - b), 64'd3);
    chk("cosh0", outs[b], 64'd3);
    chk("cosh1", outs[b+1], 64'd8);
    chk("cosh2", outs[b+2], 64'd25);
    chk("cosh_rdy", 64'(rdy_n - r0), 64'd1);
    chk("cosh_rdy_last", 64'(rdy_doe_n - d0), 64'd1);
    chk("cosh_starts", 64'(cs_n - c0), 64'd3);
    chk("cosh_sinh0", 64'(ss_n - s0), 64'd0);

    // sinh, 2 elements: sinh(3)=8, sinh(5)=68
    b = outs.size(); r0 = rdy_n; c0 = cs_n; s0 = ss_n;
    go(1'b1, 64'd2);
    send(64'd3); wait_out(b + 1);
    send(64'd5); wait_out(b + 2);
    ticks(5);
    chk("sinh0", outs[b], 64'd8);
    chk("sinh1", outs[b+1], 64'd68);
    chk("sinh_rdy", 64'(rdy_n - r0), 64'd1);
    chk("sinh_starts", 64'(ss_n - s0), 64'd2);
    chk("sinh_cosh0", 64'(cs_n - c0), 64'd0);

    // overflow: 8 back-to-back inputs into a 4-deep buffer
    b = outs.size(); r0 = rdy_n;
    v[0] = 1; v[1] = 2; v[2] = 3; v[3] = 4;
    v[4] = 5; v[5] = 0; v[6] = 1; v[7] = 2;
    full_seen = 1'b0;
    go(1'b0, 64'd8);
    for (int i = 0; i < 8; i++) begin
      den = 1'b1;
      din = v[i];
      tick();
      if (ffull) full_seen = 1'b1;
    end
    den = 1'b0;
    ticks(150);
    chk("ovf_full_seen", 64'(full_seen), 64'd1);
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("ovf_short", 64'(outs.size() - b < 8), 64'd1);
    chk("ovf_no_rdy", 64'(rdy_n - r0), 64'd0);
    for (int i = 0; i < 8 && rdy_n == r0; i++) begin
      c0 = outs.size();
      send(64'd2);
      wait_out(c0 + 1);
      tick();
    end
    ticks(5);
    chk("ovf_total", 64'(outs.size() - b), 64'd8);
    chk("ovf_rdy", 64'(rdy_n - r0), 64'd1);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    b = outs.size(); r0 = rdy_n;
    go(1'b0, 64'd1);
    chk("ovf_cleared", 64'(ovf), 64'd0);
    send(64'd1); wait_out(b + 1);
    ticks(3);
    chk("ovf_next_val", outs[b], 64'd1);
    chk("ovf_next_rdy", 64'(rdy_n - r0), 64'd1);

    // zero-length vector
    b = outs.size(); r0 = rdy_n;
    go(1'b0, 64'd0);
    chk("zero_rdy_hi", 64'(ready), 64'd1);
    chk("zero_doe", 64'(doe), 64'd0);
    tick();
    chk("zero_rdy_lo", 64'(ready), 64'd0);
    ticks(10);
    chk("zero_outs", 64'(outs.size() - b), 64'd0);
    chk("zero_rdy_n", 64'(rdy_n - r0), 64'd1);

    // START/SIZE_IN/MODE changes mid-vector are ignored
    b = outs.size(); r0 = rdy_n; c0 = cs_n; s0 = ss_n;
    go(1'b0, 64'd2);
    send(64'd3); wait_out(b + 1);
    start = 1'b1; mode = 1'b1; size_in = 64'd5;
    tick();
    start = 1'b0;
    send(64'd2); wait_out(b + 2);
    ticks(40);
    chk("mid_n", 64'(outs.size() - b), 64'd2);
    chk("mid0", outs[b], 64'd8);
    chk("mid1", outs[b+1], 64'd3);
    chk("mid_rdy", 64'(rdy_n - r0), 64'd1);
    chk("mid_cosh", 64'(cs_n - c0), 64'd2);
    chk("mid_sinh", 64'(ss_n - s0), 64'd0);

    // asynchronous reset mid-vector
    b = outs.size();
    go(1'b0, 64'd4);
    send(64'd2); wait_out(b + 1);
    send(64'd3); wait_out(b + 2);
    tick();
    chk("pre_rst_dout", dout, 64'd8);
    send(64'd4);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_dout", dout, 64'd0);
    chk("arst_doe", 64'(doe), 64'd0);
    chk("arst_ready", 64'(ready), 64'd0);
    chk("arst_ovf", 64'(ovf), 64'd0);
    chk("arst_full", 64'(ffull), 64'd0);
    ticks(2);
    rst_n = 1'b1;
    b = outs.size(); r0 = rdy_n;
    send(64'd5);
    ticks(40);
    chk("post_rst_outs", 64'(outs.size() - b), 64'd0);
    chk("post_rst_rdy", 64'(rdy_n - r0), 64'd0);
    chk("post_rst_ovf", 64'(ovf), 64'd0);
    go(1'b1, 64'd1);
    send(64'd4); wait_out(b + 1);
    ticks(3);
    chk("post_rst_val", outs[b], 64'd25);
    chk("post_rst_rdy1", 64'(rdy_n - r0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
